product_accumulator: RTL and testbench

// Downstream consumer of the Multiplier stage: captures each 2*BITS-bit product on the

---
 rtl/product_accumulator.sv | 120 ++++++++++++
 tb/tb_product_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: captures each product on the multiplier's finished pulse
// and sums TERMS of them. The result is held behind a valid/ready handshake, and
// the multiplier is stalled while the result waits. Wrap-around overflow is
// tracked, and so are products that arrive while stalled.
module product_accumulator #(
  parameter int BITS     = 8,
  parameter int TERMS    = 4,
  parameter int ACC_BITS = 2*BITS + $clog2(TERMS)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_finished,
  input  logic [2*BITS-1:0]            i_product,
  input  logic                         i_clear,
  output logic                         o_stall,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [ACC_BITS-1:0]          o_sum,
  output logic [$clog2(TERMS+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_dropped,
  output logic                         o_state     // debug: 0 = ACCUM, 1 = DONE
);

  localparam int CW = $clog2(TERMS+1);
  localparam logic [CW-1:0] LAST = CW'(TERMS-1);

  typedef enum logic {ST_ACCUM = 1'b0, ST_DONE = 1'b1} state_e;

  // Handshake: o_sum transfers on a cycle where o_valid & i_ready are both high
  // at the rising edge. o_valid stays high and o_sum stays stable until that
  // happens. o_valid never depends on i_ready.

  state_e state_q, state_d;
  logic [ACC_BITS-1:0] sum_q, sum_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                drop_q, drop_d;
  logic [ACC_BITS:0]   add_w;

  // Widen to ACC_BITS+1 so the carry out of the top bit is visible.
  assign add_w = {1'b0, sum_q} + {{(ACC_BITS+1-2*BITS){1'b0}}, i_product};

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= ST_ACCUM;
    else         state_q <= state_d;
  end

  // Next-state logic. A clear overrides everything else.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (i_finished && count_q == LAST) state_d = ST_DONE;
        ST_DONE:  if (i_ready) state_d = ST_ACCUM;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  // Output decode. These are flop outputs, so there is no combinational path
  // from any input.
  always_comb begin
    o_valid = (state_q == ST_DONE);
    o_stall = (state_q == ST_DONE);
    o_state = state_q;
  end

  // Datapath next-state: accumulate in ACCUM, freeze in DONE, clear on handshake.
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (i_clear) begin
      // A product that arrives with the clear is silently lost.
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
    end else if (state_q == ST_ACCUM) begin
      if (i_finished) begin
        sum_d   = add_w[ACC_BITS-1:0];
        count_d = count_q + CW'(1);
        ovf_d   = ovf_q | add_w[ACC_BITS];
      end
    end else begin
      if (i_finished) drop_d = 1'b1;
      if (i_ready) begin
        sum_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign o_sum      = sum_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_dropped  = drop_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a directed vector table on the default
// configuration, plus hand sequences for overflow (ACC_BITS=16), async reset
// and TERMS=1.
`timescale 1ns/1ps
module tb_product_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        fin = 1'b0;
  logic [15:0] prod = '0;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;

  // DUT A: BITS=8, TERMS=4, ACC_BITS=18
  logic a_stall, a_valid, a_ovf, a_drop, a_state;
  logic [17:0] a_sum;
  logic [2:0]  a_cnt;
  product_accumulator #(.BITS(8), .TERMS(4)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_finished(fin), .i_product(prod),
    .i_clear(clr), .o_stall(a_stall), .o_valid(a_valid), .i_ready(rdy),
    .o_sum(a_sum), .o_count(a_cnt), .o_overflow(a_ovf), .o_dropped(a_drop),
    .o_state(a_state));

  // DUT B: ACC_BITS=16 for wrap-around
  logic b_stall, b_valid, b_ovf, b_drop, b_state;
  logic [15:0] b_sum;
  logic [2:0]  b_cnt;
  product_accumulator #(.BITS(8), .TERMS(4), .ACC_BITS(16)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_finished(fin), .i_product(prod),
    .i_clear(clr), .o_stall(b_stall), .o_valid(b_valid), .i_ready(rdy),
    .o_sum(b_sum), .o_count(b_cnt), .o_overflow(b_ovf), .o_dropped(b_drop),
    .o_state(b_state));

  // DUT C: TERMS=1
  logic c_stall, c_valid, c_ovf, c_drop, c_state;
  logic [15:0] c_sum;
  logic [0:0]  c_cnt;
  product_accumulator #(.BITS(8), .TERMS(1)) dut_c (
    .i_clock(clk), .i_reset(rst), .i_finished(fin), .i_product(prod),
    .i_clear(clr), .o_stall(c_stall), .o_valid(c_valid), .i_ready(rdy),
    .o_sum(c_sum), .o_count(c_cnt), .o_overflow(c_ovf), .o_dropped(c_drop),
    .o_state(c_state));

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        fin;
    logic [15:0] prod;
    logic        clr;
    logic        rdy;
    logic [17:0] sum;
    logic [2:0]  cnt;
    logic        v;
    logic        ov;
    logic        dr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic f, input int p, input logic c, input logic r,
                     input int s, input int n, input logic v, input logic ov, input logic dr);
    vec_t e;
    e.fin = f; e.prod = 16'(p); e.clr = c; e.rdy = r;
    e.sum = 18'(s); e.cnt = 3'(n); e.v = v; e.ov = ov; e.dr = dr;
    vq.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    fin = 1'b0; prod = '0; clr = 1'b0; rdy = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int p);
    fin = 1'b1; prod = 16'(p);
    tick();
    fin = 1'b0; prod = '0;
  endtask

  // ---------------- test ----------------
  initial begin
    // Reset state, checked before any clock edge.
    #2;
    check("rst_sum",   a_sum,   0);
    check("rst_cnt",   a_cnt,   0);
    check("rst_valid", a_valid, 0);
    check("rst_stall", a_stall, 0);
    check("rst_ovf",   a_ovf,   0);
    check("rst_drop",  a_drop,  0);
    apply_reset();

    // fin prod clr rdy | sum cnt v ov dr
    // Basic sum 10+20+30+40
    add(1,10,0,0,  10,1,0,0,0);
    add(1,20,0,0,  30,2,0,0,0);
    add(1,30,0,0,  60,3,0,0,0);
    add(1,40,0,0, 100,4,1,0,0);
    add(0, 0,0,0, 100,4,1,0,0);
    add(0, 0,0,1,   0,0,0,0,0);
    // Back-pressure: result 10 held for 5 cycles, a product dropped
    add(1, 1,0,0,   1,1,0,0,0);
    add(1, 2,0,0,   3,2,0,0,0);
    add(1, 3,0,0,   6,3,0,0,0);
    add(1, 4,0,0,  10,4,1,0,0);
    add(0, 0,0,0,  10,4,1,0,0);
    add(0, 0,0,0,  10,4,1,0,0);
    add(0, 0,0,0,  10,4,1,0,0);
    add(0, 0,0,0,  10,4,1,0,0);
    add(1,99,0,0,  10,4,1,0,1);
    add(0, 0,0,1,   0,0,0,0,1);
    // Clear mid-sum, with a pulse in the same cycle
    add(1, 5,0,0,   5,1,0,0,1);
    add(1, 6,0,0,  11,2,0,0,1);
    add(1, 7,1,0,   0,0,0,0,0);
    add(1, 1,0,0,   1,1,0,0,0);
    add(1, 2,0,0,   3,2,0,0,0);
    add(1, 3,0,0,   6,3,0,0,0);
    add(1, 4,0,0,  10,4,1,0,0);
    add(0, 0,0,1,   0,0,0,0,0);
    // Handshake in the same cycle as a pulse: product dropped, next pulse starts a new sum
    add(1,10,0,0,  10,1,0,0,0);
    add(1,20,0,0,  30,2,0,0,0);
    add(1,30,0,0,  60,3,0,0,0);
    add(1,40,0,0, 100,4,1,0,0);
    add(1,50,0,1,   0,0,0,0,1);
    add(1, 7,0,0,   7,1,0,0,1);
    // Clear while DONE, ignoring i_ready
    add(1, 8,0,0,  15,2,0,0,1);
    add(1, 9,0,0,  24,3,0,0,1);
    add(1,10,0,0,  34,4,1,0,1);
    add(0, 0,1,0,   0,0,0,0,0);

    foreach (vq[i]) begin
      fin = vq[i].fin; prod = vq[i].prod; clr = vq[i].clr; rdy = vq[i].rdy;
      tick();
      check($sformatf("v%0d_sum", i),   a_sum,   vq[i].sum);
      check($sformatf("v%0d_cnt", i),   a_cnt,   vq[i].cnt);
      check($sformatf("v%0d_valid", i), a_valid, vq[i].v);
      check($sformatf("v%0d_stall", i), a_stall, vq[i].v);
      check($sformatf("v%0d_state", i), a_state, vq[i].v);
      check($sformatf("v%0d_ovf", i),   a_ovf,   vq[i].ov);
      check($sformatf("v%0d_drop", i),  a_drop,  vq[i].dr);
    end
    idle_inputs();

    // Async reset between edges while DONE, with o_dropped set
    apply_reset();
    pulse(1); pulse(2); pulse(3); pulse(4);
    fin = 1'b1; prod = 16'd9; tick(); fin = 1'b0;
    check("ar_pre_valid", a_valid, 1);
    check("ar_pre_drop",  a_drop,  1);
    #3 rst = 1'b1;
    #1;
    check("ar_sum",   a_sum,   0);
    check("ar_cnt",   a_cnt,   0);
    check("ar_valid", a_valid, 0);
    check("ar_stall", a_stall, 0);
    check("ar_drop",  a_drop,  0);
    #1 rst = 1'b0;
    tick();

    // Overflow on the 16-bit accumulator: 4 x 65025
    apply_reset();
    pulse(65025);
    check("ov1_sum", b_sum, 65025);
    check("ov1_ovf", b_ovf, 0);
    pulse(65025);
    check("ov2_sum", b_sum, 64514);
    check("ov2_ovf", b_ovf, 1);
    pulse(65025); pulse(65025);
    check("ov4_sum",   b_sum,   63492);
    check("ov4_ovf",   b_ovf,   1);
    check("ov4_valid", b_valid, 1);
    check("ov4_cnt",   b_cnt,   4);
    rdy = 1'b1; tick(); rdy = 1'b0;
    check("ovh_ovf",   b_ovf,   0);
    check("ovh_sum",   b_sum,   0);
    check("ovh_valid", b_valid, 0);

    // TERMS=1: every accepted pulse completes a result
    apply_reset();
    pulse(200);
    check("t1_valid", c_valid, 1);
    check("t1_stall", c_stall, 1);
    check("t1_sum",   c_sum,   200);
    check("t1_cnt",   c_cnt,   1);
    pulse(33);
    check("t1_drop",  c_drop,  1);
    check("t1_hold",  c_sum,   200);
    rdy = 1'b1; tick(); rdy = 1'b0;
    check("t1h_valid", c_valid, 0);
    check("t1h_sum",   c_sum,   0);
    pulse(77);
    check("t1b_sum",   c_sum,   77);
    check("t1b_valid", c_valid, 1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
